// File: rtl/cr16_pkg.sv
// Shared CR16 definitions: PSR flag bit positions, the default PSR index,
// and the packed 5-bit flag-vector order {N,Z,F,L,C} used on the ALU
// flag port, plus helpers to move between the flag vector and PSR bits.
package cr16_pkg;

  localparam int unsigned NFLAGS = 5;

  // Flag bit positions inside the PSR word.
  localparam int unsigned C_IND = 0;
  localparam int unsigned L_IND = 2;
  localparam int unsigned F_IND = 5;
  localparam int unsigned Z_IND = 6;
  localparam int unsigned N_IND = 7;

  localparam int unsigned PSR_ADDR_DEF = 15;

  // Positions inside the 5-bit flag vector {N,Z,F,L,C}.
  localparam int unsigned FV_C = 0;
  localparam int unsigned FV_L = 1;
  localparam int unsigned FV_F = 2;
  localparam int unsigned FV_Z = 3;
  localparam int unsigned FV_N = 4;

  typedef logic [NFLAGS-1:0] flags_t;

  // Places the flag vector at its PSR bit positions; all other bits 0.
  function automatic logic [7:0] flags_to_psr8(input flags_t f);
    logic [7:0] b;
    b        = '0;
    b[C_IND] = f[FV_C];
    b[L_IND] = f[FV_L];
    b[F_IND] = f[FV_F];
    b[Z_IND] = f[FV_Z];
    b[N_IND] = f[FV_N];
    return b;
  endfunction

  // Extracts the flag vector from the low byte of a PSR-formatted word.
  function automatic flags_t psr8_to_flags(input logic [7:0] b);
    flags_t f;
    f       = '0;
    f[FV_C] = b[C_IND];
    f[FV_L] = b[L_IND];
    f[FV_F] = b[F_IND];
    f[FV_Z] = b[Z_IND];
    f[FV_N] = b[N_IND];
    return f;
  endfunction

endpackage

// File: rtl/cr16_scoreboard.sv
// Pending-write scoreboard: one bit per register.
//   set_en/set_addr : mark a register pending (load issued)
//   clr_en/clr_addr : clear a register's pending bit (write returned)
//   q_addr1/2       : query addresses; q_busy1/2 report the stored bit
// A set and clear of the same address in one cycle leaves the bit set.
module cr16_scoreboard #(
  parameter int unsigned REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set_en,
  input  logic [REGBITS-1:0] set_addr,
  input  logic               clr_en,
  input  logic [REGBITS-1:0] clr_addr,
  input  logic [REGBITS-1:0] q_addr1,
  input  logic [REGBITS-1:0] q_addr2,
  output logic               q_busy1,
  output logic               q_busy2
);

  localparam int unsigned NREG = 2**REGBITS;

  logic [NREG-1:0] pending_q, pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_addr] = 1'b0;
    // Applied after the clear so a newly issued load wins.
    if (set_en) pending_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign q_busy1 = pending_q[q_addr1];
  assign q_busy2 = pending_q[q_addr2];

endmodule

// File: rtl/cr16_regfile_sb.sv
// CR16 register file with scoreboard.
//   Read ports  : rd_addr1/2 -> rd_data1/2 (combinational), busy1/2
//   Write port  : wr_en/wr_addr/wr_data (PSR address ignored)
//   PSR         : psr_wr_en loads flags from wr_data; f_en/f_mask/flags_in
//                 update individual flags with priority over psr_wr_en;
//                 psr_out is the registered PSR
//   Scoreboard  : sb_set/sb_addr mark a register pending; writes clear it
// BYPASS=1 forwards same-cycle write data (and hides the pending bit) on
// reads of the written address. PSR reads are never bypassed.
module cr16_regfile_sb
  import cr16_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned REGBITS    = 4,
  parameter int unsigned PSR_ADDR   = PSR_ADDR_DEF,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REGBITS-1:0]    rd_addr1,
  input  logic [REGBITS-1:0]    rd_addr2,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  wr_en,
  input  logic [REGBITS-1:0]    wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  psr_wr_en,
  input  logic                  f_en,
  input  logic [NFLAGS-1:0]     f_mask,
  input  logic [NFLAGS-1:0]     flags_in,
  input  logic                  sb_set,
  input  logic [REGBITS-1:0]    sb_addr,
  output logic [DATA_WIDTH-1:0] psr_out
);

  localparam int unsigned        NREG  = 2**REGBITS;
  localparam logic [REGBITS-1:0] PSR_A = PSR_ADDR[REGBITS-1:0];

  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [DATA_WIDTH-1:0] regs_d [NREG];
  flags_t                flags_q, flags_d;

  logic wr_gp;
  logic sb_set_gp;
  logic pend1, pend2;
  logic fwd1, fwd2;

  assign wr_gp     = wr_en  && (wr_addr != PSR_A);
  assign sb_set_gp = sb_set && (sb_addr != PSR_A);

  always_comb begin
    regs_d = regs_q;
    if (wr_gp) regs_d[wr_addr] = wr_data;
  end

  always_comb begin
    flags_d = flags_q;
    if (psr_wr_en) flags_d = psr8_to_flags(wr_data[7:0]);
    if (f_en)      flags_d = (flags_d & ~f_mask) | (flags_in & f_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q  <= '{default: '0};
      flags_q <= '0;
    end else begin
      regs_q  <= regs_d;
      flags_q <= flags_d;
    end
  end

  cr16_scoreboard #(
    .REGBITS (REGBITS)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (sb_set_gp),
    .set_addr (sb_addr),
    .clr_en   (wr_gp),
    .clr_addr (wr_addr),
    .q_addr1  (rd_addr1),
    .q_addr2  (rd_addr2),
    .q_busy1  (pend1),
    .q_busy2  (pend2)
  );

  assign psr_out = DATA_WIDTH'(flags_to_psr8(flags_q));

  // wr_gp already excludes the PSR address, so forwarding never hits it.
  assign fwd1 = BYPASS && wr_gp && (wr_addr == rd_addr1);
  assign fwd2 = BYPASS && wr_gp && (wr_addr == rd_addr2);

  always_comb begin
    if (rd_addr1 == PSR_A) rd_data1 = psr_out;
    else if (fwd1)         rd_data1 = wr_data;
    else                   rd_data1 = regs_q[rd_addr1];
    if (rd_addr2 == PSR_A) rd_data2 = psr_out;
    else if (fwd2)         rd_data2 = wr_data;
    else                   rd_data2 = regs_q[rd_addr2];
  end

  assign busy1 = pend1 && !fwd1;
  assign busy2 = pend2 && !fwd2;

endmodule
